// File: rtl/mem_bus_bridge.sv
// Bridges the core's MEM-stage data request onto a single Wishbone classic cycle,
// stalling the pipeline until ack or timeout and holding read data while ctrl stalls.
module mem_bus_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i
);

   localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CntW:0] TimeoutVal = TIMEOUT[CntW:0];

   typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       rd_buf_q, rd_buf_d;
   logic              cyc_q, cyc_d;
   logic              stb_q, stb_d;
   logic              we_q, we_d;
   logic [31:0]       adr_q, adr_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       dat_q, dat_d;
   logic [CntW:0]     cnt_inc;
   logic              timeout;
   logic [31:0]       ret_data;

   // cnt_q counts completed BUSY cycles; abort once the current one is the TIMEOUT-th.
   assign cnt_inc = {1'b0, cnt_q} + 1'b1;
   assign timeout = (cnt_inc == TimeoutVal);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_buf_d   = rd_buf_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      dat_d      = dat_q;
      ret_data   = 32'h0;
      stallreq_o = 1'b0;
      cpu_data_o = 32'h0;
      bus_err_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_ce_i) begin
               stallreq_o = 1'b1;
               cyc_d      = 1'b1;
               stb_d      = 1'b1;
               we_d       = cpu_we_i;
               adr_d      = cpu_addr_i;
               sel_d      = cpu_we_i ? cpu_sel_i : 4'hF;
               dat_d      = cpu_data_i;
               cnt_d      = '0;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            if (wb_ack_i || timeout) begin
               ret_data   = (wb_ack_i && !we_q) ? wb_dat_i : 32'h0;
               cpu_data_o = ret_data;
               rd_buf_d   = ret_data;
               bus_err_o  = !wb_ack_i;
               cyc_d      = 1'b0;
               stb_d      = 1'b0;
               state_d    = (|stall_i) ? StHold : StIdle;
            end else begin
               stallreq_o = 1'b1;
               cnt_d      = cnt_q + 1'b1;
            end
         end
         StHold: begin
            cpu_data_o = rd_buf_q;
            if (!(|stall_i)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Combinational outputs stay quiet for the whole reset assertion.
      if (!rst) begin
         stallreq_o = 1'b0;
         cpu_data_o = 32'h0;
         bus_err_o  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         rd_buf_q <= 32'h0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= 32'h0;
         sel_q    <= 4'h0;
         dat_q    <= 32'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_buf_q <= rd_buf_d;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         dat_q    <= dat_d;
      end
   end

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = we_q;
   assign wb_adr_o = adr_q;
   assign wb_sel_o = sel_q;
   assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of one outstanding core access.
module tb_mem_bus_bridge;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        ce, we;
   logic [31:0] adr, wdat, rdat;
   logic [3:0]  sel;
   logic        ack;
   logic [31:0] cpu_data;
   logic        stallreq, bus_err, wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_adr, wb_dat;
   logic [3:0]  wb_sel;

   always #5 clk = ~clk;

   mem_bus_bridge #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .stall_i(stall), .cpu_ce_i(ce), .cpu_we_i(we),
      .cpu_addr_i(adr), .cpu_sel_i(sel), .cpu_data_i(wdat), .cpu_data_o(cpu_data),
      .stallreq_o(stallreq), .bus_err_o(bus_err), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
      .wb_we_o(wb_we), .wb_adr_o(wb_adr), .wb_sel_o(wb_sel), .wb_dat_o(wb_dat),
      .wb_dat_i(rdat), .wb_ack_i(ack)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Model: at most one outstanding access (pend) or one held result (hold).
   typedef struct packed {
      bit          pend;
      bit          hold;
      bit          we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] held;
      logic [31:0] w;
   } model_t;

   model_t m = '0;
   model_t n = '0;

   always @(negedge clk) begin
      bit          done, tmo, es, ee;
      logic [31:0] ed;
      n    = m;
      tmo  = m.pend && !ack && (m.w + 1 == TO);
      done = m.pend && (ack || tmo);
      ed = 32'h0; es = 1'b0; ee = 1'b0;
      if (m.pend) begin
         es = !done;
         ee = tmo;
         ed = (ack && !m.we) ? rdat : 32'h0;
      end else if (m.hold) begin
         ed = m.held;
      end else begin
         es = ce;
      end
      if (chk_en) begin
         chk("m_stallreq", {31'b0, stallreq}, {31'b0, es && rst});
         chk("m_bus_err", {31'b0, bus_err}, {31'b0, ee && rst});
         chk("m_cpu_data", cpu_data, rst ? ed : 32'h0);
         chk("m_cyc", {31'b0, wb_cyc}, {31'b0, m.pend});
         chk("m_stb", {31'b0, wb_stb}, {31'b0, m.pend});
         chk("m_we", {31'b0, wb_we}, {31'b0, m.we});
         chk("m_adr", wb_adr, m.adr);
         chk("m_sel", {28'b0, wb_sel}, {28'b0, m.sel});
         chk("m_dat", wb_dat, m.dat);
      end
      if (!rst) begin
         n = '0;
      end else if (m.pend) begin
         if (done) begin
            n.pend = 1'b0;
            n.held = ed;
            n.hold = (stall != 6'd0);
         end else begin
            n.w = m.w + 1;
         end
      end else if (m.hold) begin
         if (stall == 6'd0) n.hold = 1'b0;
      end else if (ce) begin
         n.pend = 1'b1;
         n.w    = 32'd0;
         n.we   = we;
         n.adr  = adr;
         n.sel  = we ? sel : 4'hF;
         n.dat  = wdat;
      end
   end

   always @(posedge clk) m = n;

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      rst = 1'b1; ce = 1'b0; we = 1'b0; ack = 1'b0; stall = 6'd0;
   endtask

   initial begin
      rst = 1'b0; ce = 1'b0; we = 1'b0; adr = 32'h0; sel = 4'h0; wdat = 32'h0;
      ack = 1'b0; rdat = 32'h0; stall = 6'd0;
      next_cyc();
      next_cyc();
      chk_en = 1'b1;
      #1;
      chk("rst_cyc", {31'b0, wb_cyc}, 32'd0);
      chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
      chk("rst_adr", wb_adr, 32'd0);
      next_cyc(); quiet();

      // Read, ack three cycles after the request.
      next_cyc(); ce = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'h3; wdat = 32'h55;
      #1 chk("rd_stall_n", {31'b0, stallreq}, 32'd1);
      next_cyc();
      #1 chk("rd_sel_f", {28'b0, wb_sel}, 32'hF);
      chk("rd_stall_n1", {31'b0, stallreq}, 32'd1);
      next_cyc();
      #1 chk("rd_stall_n2", {31'b0, stallreq}, 32'd1);
      next_cyc(); ack = 1'b1; rdat = 32'hDEADBEEF;
      #1 chk("rd_stall_n3", {31'b0, stallreq}, 32'd0);
      chk("rd_data_n3", cpu_data, 32'hDEADBEEF);
      next_cyc(); quiet();
      #1 chk("rd_cyc_drop", {31'b0, wb_cyc}, 32'd0);

      // Byte write, ack on the first bus cycle.
      next_cyc(); ce = 1'b1; we = 1'b1; adr = 32'h21; sel = 4'b0100; wdat = 32'h00AB0000;
      next_cyc(); ack = 1'b1; rdat = 32'hFFFFFFFF;
      #1 chk("wr_we", {31'b0, wb_we}, 32'd1);
      chk("wr_sel", {28'b0, wb_sel}, 32'h4);
      chk("wr_dat", wb_dat, 32'h00AB0000);
      chk("wr_data0", cpu_data, 32'd0);
      next_cyc(); quiet();
      #1 chk("wr_cyc_drop", {31'b0, wb_cyc}, 32'd0);
      next_cyc();
      #1 chk("wr_one_cyc", {31'b0, wb_cyc}, 32'd0);

      // Ack under ctrl stall: result held, no re-issue even with ce high.
      next_cyc(); ce = 1'b1; we = 1'b0; adr = 32'h40;
      next_cyc(); ack = 1'b1; rdat = 32'h12345678; stall = 6'b000111;
      #1 chk("hold_ack", cpu_data, 32'h12345678);
      for (int k = 0; k < 2; k++) begin
         next_cyc(); ack = 1'b0; rdat = 32'h0;
         #1 chk("hold_data", cpu_data, 32'h12345678);
         chk("hold_no_cyc", {31'b0, wb_cyc}, 32'd0);
         chk("hold_stallreq", {31'b0, stallreq}, 32'd0);
      end
      next_cyc(); quiet();
      #1 chk("hold_last", cpu_data, 32'h12345678);
      next_cyc();
      #1 chk("hold_idle", cpu_data, 32'd0);
      chk("hold_idle_cyc", {31'b0, wb_cyc}, 32'd0);

      // Timeout with no ack.
      next_cyc(); ce = 1'b1; we = 1'b0; adr = 32'h80;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) next_cyc();
         #1 chk("to_stall", {31'b0, stallreq}, 32'd1);
         chk("to_no_err", {31'b0, bus_err}, 32'd0);
      end
      next_cyc(); rdat = 32'hBAD0BAD0;
      #1 chk("to_err", {31'b0, bus_err}, 32'd1);
      chk("to_stall_off", {31'b0, stallreq}, 32'd0);
      chk("to_data0", cpu_data, 32'd0);
      next_cyc(); quiet();
      #1 chk("to_cyc_drop", {31'b0, wb_cyc}, 32'd0);
      chk("to_err_pulse", {31'b0, bus_err}, 32'd0);

      // Reset in the second BUSY cycle, late ack, then a fresh request.
      next_cyc(); ce = 1'b1; we = 1'b0; adr = 32'hC0;
      next_cyc();
      next_cyc(); rst = 1'b0;
      #1 chk("rb_stall_rst", {31'b0, stallreq}, 32'd0);
      next_cyc(); quiet(); ack = 1'b1; rdat = 32'h11111111;
      #1 chk("rb_cyc", {31'b0, wb_cyc}, 32'd0);
      chk("rb_adr", wb_adr, 32'd0);
      chk("rb_late_ack", cpu_data, 32'd0);
      next_cyc(); ack = 1'b0; ce = 1'b1; adr = 32'hC4;
      #1 chk("rb_new_req", {31'b0, stallreq}, 32'd1);
      next_cyc(); ack = 1'b1; rdat = 32'hCAFEF00D;
      #1 chk("rb_new_data", cpu_data, 32'hCAFEF00D);

      // Back-to-back reads with ce held high.
      next_cyc(); ack = 1'b0; ce = 1'b1; adr = 32'h100;
      next_cyc(); ack = 1'b1; rdat = 32'h0A0A0A0A;
      #1 chk("b2b_first", cpu_data, 32'h0A0A0A0A);
      next_cyc(); ack = 1'b0; adr = 32'h104;
      #1 chk("b2b_gap_cyc", {31'b0, wb_cyc}, 32'd0);
      chk("b2b_gap_stall", {31'b0, stallreq}, 32'd1);
      next_cyc();
      #1 chk("b2b_second_cyc", {31'b0, wb_cyc}, 32'd1);
      chk("b2b_second_adr", wb_adr, 32'h104);
      next_cyc(); quiet();

      for (int i = 0; i < 3000; i++) begin
         next_cyc();
         rst   = ($urandom_range(0, 199) != 0);
         ce    = ($urandom_range(0, 2) != 0);
         we    = 1'($urandom_range(0, 1));
         adr   = $urandom;
         sel   = 4'($urandom_range(0, 15));
         wdat  = $urandom;
         ack   = ($urandom_range(0, 3) == 0);
         rdat  = $urandom;
         stall = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      end
      next_cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles a bus access waits for ack before it is aborted.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 stall_i  input  6  pipeline stall vector from ctrl; bit 0 pc, bit 1 IF, bit 2 ID, bit 3 EX, bit 4 MEM, bit 5 WB.
REQ-005 cpu_ce_i  input  1  core data-memory request valid.
REQ-006 cpu_we_i  input  1  1 = write, 0 = read.
REQ-007 cpu_addr_i  input  32  byte address.
REQ-008 cpu_sel_i  input  4  byte lane enables.
REQ-009 cpu_data_i  input  32  write data.
REQ-010 cpu_data_o  output  32  read data returned to MEM stage.
REQ-011 stallreq_o  output  1  stall request to ctrl; combinational.
REQ-012 bus_err_o  output  1  one-cycle pulse on timeout abort.
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  bus cycle, strobe, write enable; registered.
REQ-014 wb_adr_o  output  32  bus address; registered.
REQ-015 wb_sel_o  output  4  bus byte lanes; registered.
REQ-016 wb_dat_o  output  32  bus write data; registered.
REQ-017 wb_dat_i  input  32  bus read data.
REQ-018 wb_ack_i  input  1  bus transfer complete.

Function
REQ-019 FSM states SHALL be IDLE, BUSY, HOLD.
- IDLE, cpu_ce_i=1: latch address, sel, we and data into wb_* outputs; assert cyc/stb; go to BUSY; stallreq_o=1 in the same cycle.
- IDLE, cpu_ce_i=0: wb_cyc_o=wb_stb_o=0; stallreq_o=0; cpu_data_o=0.
- BUSY, wb_ack_i=0: hold all wb_* outputs; stallreq_o=1; increment wait counter.
- BUSY, wb_ack_i=1: cpu_data_o=wb_dat_i combinationally (0 on writes); stallreq_o=0; deassert cyc/stb next edge; capture wb_dat_i into rd_buf. Next state is HOLD if stall_i!=0 that cycle, otherwise IDLE.
- HOLD: cpu_data_o=rd_buf; stallreq_o=0; no bus activity; stay while stall_i!=0; go to IDLE when stall_i==0.
REQ-020 Minimum access latency SHALL be 2 cycles: request cycle N, ack accepted no earlier than N+1, data valid at the core in the ack cycle.
REQ-021 Wait counter SHALL be 8+ bits wide and cleared on entering BUSY. When it reaches TIMEOUT without ack: cpu_data_o=0, stallreq_o=0, bus_err_o=1 for that cycle, cyc/stb dropped next edge, next state chosen as on ack.
REQ-022 Ack and timeout in the same cycle SHALL resolve as ack, with no bus_err_o.
REQ-023 wb_ack_i outside BUSY SHALL be ignored.
REQ-024 cpu_ce_i in HOLD SHALL NOT start a new access; the request is re-evaluated in IDLE.
REQ-025 Exactly one bus transaction SHALL be issued per core request; no re-issue while the core remains stalled.
REQ-026 wb_sel_o SHALL equal cpu_sel_i on writes and 4'b1111 on reads.

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, clear wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, rd_buf, the wait counter and bus_err_o to 0; cpu_data_o=0, stallreq_o=0 while rst=0.
REQ-028 Reset during BUSY SHALL abandon the transaction (cyc/stb low after the edge) with no retry after reset release.

Verification
REQ-029 Read, ack at N+3: ce=1, we=0, addr=0x00000010; wb_dat_i=0xDEADBEEF -> stallreq_o=1 for N..N+2, 0 at N+3; cpu_data_o=0xDEADBEEF at N+3; wb_sel_o=4'hF.
REQ-030 Byte write: addr=0x00000021, sel=4'b0100, data=0x00AB0000, ack at N+1 -> wb_we_o=1, wb_sel_o=4'b0100, wb_dat_o=0x00AB0000 at N+1; one cyc only.
REQ-031 Ack while stall_i=6'b000111 for 3 cycles, rd data 0x12345678 -> HOLD; cpu_data_o=0x12345678 each held cycle; no second wb_stb_o rise; IDLE after stall_i=0.
REQ-032 TIMEOUT=4, no ack -> stallreq_o high for 4 cycles, then bus_err_o=1 for one cycle and cpu_data_o=0; cyc low the next cycle.
REQ-033 rst=0 in BUSY cycle 2 -> all outputs 0 after the edge; a late ack is ignored; a fresh request after release completes normally.
REQ-034 Back-to-back requests: ce held high across two reads -> two separate cyc assertions with at least one IDLE cycle between.
